// File: rtl/zbuf_rmw_unit.sv
// Depth-test read-modify-write engine: compares a word of candidate pixels against
// stored depths (SRAM or one-entry last-word cache) and writes back passing pixels.
module zbuf_rmw_unit #(
  parameter int PIX_PER_WORD = 16,
  parameter int DEPTH_W      = 21,
  parameter int COLOR_W      = 24,
  parameter int ADDR_W       = 16,
  parameter int SRAM_RD_LAT  = 1,
  parameter int CNT_W        = 32
) (
  input  logic                            clk,
  input  logic                            srst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ADDR_W-1:0]               in_addr,
  input  logic [PIX_PER_WORD-1:0]         in_mask,
  input  logic [PIX_PER_WORD*DEPTH_W-1:0] in_depth,
  input  logic [PIX_PER_WORD*COLOR_W-1:0] in_color,
  input  logic [1:0]                      cmp_mode,
  input  logic                            cache_flush,
  input  logic                            stats_clr,
  output logic                            sram_rd_en,
  output logic [ADDR_W-1:0]               sram_rd_addr,
  input  logic [PIX_PER_WORD*DEPTH_W-1:0] sram_rd_depth,
  output logic                            sram_wr_en,
  output logic [ADDR_W-1:0]               sram_wr_addr,
  output logic [PIX_PER_WORD*DEPTH_W-1:0] sram_wr_depth,
  output logic [PIX_PER_WORD*COLOR_W-1:0] sram_wr_color,
  output logic [PIX_PER_WORD-1:0]         sram_wr_mask,
  output logic [CNT_W-1:0]                pass_count,
  output logic                            busy
);

  localparam int PD_W  = PIX_PER_WORD * DEPTH_W;
  localparam int PC_W  = PIX_PER_WORD * COLOR_W;
  localparam int POP_W = $clog2(PIX_PER_WORD + 1);
  localparam int LAT_W = (SRAM_RD_LAT < 2) ? 1 : $clog2(SRAM_RD_LAT + 1);

  typedef enum logic [2:0] {IDLE, RD, WAIT, CMP, WR} state_t;
  typedef enum logic [1:0] {M_LESS, M_LEQUAL, M_ALWAYS, M_NEVER} cmp_mode_t;

  state_t                  state, state_nxt;
  logic [LAT_W-1:0]        cnt;
  logic [ADDR_W-1:0]       req_addr;
  logic [PIX_PER_WORD-1:0] req_mask;
  logic [PD_W-1:0]         req_depth;
  logic [PC_W-1:0]         req_color;
  cmp_mode_t               req_mode;
  logic                    cache_valid;
  logic [ADDR_W-1:0]       cache_addr;
  logic [PD_W-1:0]         cache_depth;
  logic [PIX_PER_WORD-1:0] pass_r, pass_c;
  logic [PD_W-1:0]         merged_r, merged_c, old_depth;
  logic [POP_W-1:0]        pop;
  logic                    accept, hit, capture, last_wait;

  assign in_ready  = (state == IDLE);
  assign busy      = !in_ready;
  assign accept    = in_valid && in_ready;
  assign hit       = cache_valid && (cache_addr == in_addr) && !cache_flush;
  assign last_wait = (state == WAIT) && (cnt == LAT_W'(1));
  assign capture   = last_wait || (state == CMP);
  assign old_depth = (state == CMP) ? cache_depth : sram_rd_depth;

  // Per-pixel compare and merge against whichever old depth is current.
  always_comb begin
    // NOTE: every variable in always_comb gets a default first so no latch is inferred.
    pass_c   = '0;
    merged_c = old_depth;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      logic [DEPTH_W-1:0] nd, od;
      logic               ok;
      nd = req_depth[i*DEPTH_W +: DEPTH_W];
      od = old_depth[i*DEPTH_W +: DEPTH_W];
      unique case (req_mode)
        M_LESS:   ok = nd < od;
        M_LEQUAL: ok = nd <= od;
        M_ALWAYS: ok = 1'b1;
        default:  ok = 1'b0;
      endcase
      pass_c[i] = req_mask[i] & ok;
      if (pass_c[i]) merged_c[i*DEPTH_W +: DEPTH_W] = nd;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) pop = pop + POP_W'(pass_r[i]);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = hit ? CMP : RD;
      RD:      state_nxt = WAIT;
      WAIT:    if (last_wait) state_nxt = WR;
      CMP:     state_nxt = WR;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      req_addr    <= '0;
      req_mask    <= '0;
      req_depth   <= '0;
      req_color   <= '0;
      req_mode    <= M_LESS;
      pass_r      <= '0;
      merged_r    <= '0;
      cache_valid <= 1'b0;
      pass_count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= state_nxt;
      if (accept) begin
        req_addr  <= in_addr;
        req_mask  <= in_mask;
        req_depth <= in_depth;
        req_color <= in_color;
        req_mode  <= cmp_mode_t'(cmp_mode);
      end
      if (state == RD)        cnt <= LAT_W'(SRAM_RD_LAT);
      else if (state == WAIT) cnt <= cnt - LAT_W'(1);
      if (capture) begin
        pass_r   <= pass_c;
        merged_r <= merged_c;
      end
      // Flush wins over the write-back refill of the same cycle.
      if (cache_flush)        cache_valid <= 1'b0;
      else if (state == WR)   cache_valid <= 1'b1;
      if (stats_clr)          pass_count <= (state == WR) ? CNT_W'(pop) : '0;
      else if (state == WR)   pass_count <= pass_count + CNT_W'(pop);
    end
  end

  // NOTE: cache tag/data need no reset; cache_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (state == WR) begin
      cache_addr  <= req_addr;
      cache_depth <= merged_r;
    end
  end

  assign sram_rd_en    = (state == RD);
  assign sram_rd_addr  = req_addr;
  assign sram_wr_en    = (state == WR) && (pass_r != '0);
  assign sram_wr_addr  = req_addr;
  assign sram_wr_depth = merged_r;
  assign sram_wr_color = req_color;
  assign sram_wr_mask  = (state == WR) ? pass_r : '0;

endmodule

// File: tb/tb_zbuf_rmw_unit.sv
// Directed bench for zbuf_rmw_unit: two instances (read latency 1 and 3) share one SRAM model.
module tb_zbuf_rmw_unit;
  localparam int P  = 16;
  localparam int DW = 21;
  localparam int CW = 24;
  localparam int AW = 16;
  typedef logic [P*DW-1:0] dvec_t;
  typedef logic [P*CW-1:0] cvec_t;

  logic clk = 1'b0;
  logic srst_n;
  logic a_valid, b_valid, a_ready, b_ready, a_busy, b_busy;
  logic [AW-1:0] in_addr;
  logic [P-1:0]  in_mask;
  dvec_t         in_depth;
  cvec_t         in_color;
  logic [1:0]    cmp_mode;
  logic          cache_flush, stats_clr;
  logic          a_rd_en, b_rd_en, a_wr_en, b_wr_en;
  logic [AW-1:0] a_rd_addr, b_rd_addr, a_wr_addr, b_wr_addr;
  dvec_t         a_rd_depth, b_rd_depth, a_wr_depth, b_wr_depth;
  cvec_t         a_wr_color, b_wr_color;
  logic [P-1:0]  a_wr_mask, b_wr_mask;
  logic [31:0]   a_pass_count, b_pass_count;

  always #5 clk = ~clk;

  zbuf_rmw_unit #(.SRAM_RD_LAT(1)) dut_a (
    .clk(clk), .srst_n(srst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_addr(in_addr), .in_mask(in_mask), .in_depth(in_depth), .in_color(in_color),
    .cmp_mode(cmp_mode), .cache_flush(cache_flush), .stats_clr(stats_clr),
    .sram_rd_en(a_rd_en), .sram_rd_addr(a_rd_addr), .sram_rd_depth(a_rd_depth),
    .sram_wr_en(a_wr_en), .sram_wr_addr(a_wr_addr), .sram_wr_depth(a_wr_depth),
    .sram_wr_color(a_wr_color), .sram_wr_mask(a_wr_mask),
    .pass_count(a_pass_count), .busy(a_busy));

  zbuf_rmw_unit #(.SRAM_RD_LAT(3)) dut_b (
    .clk(clk), .srst_n(srst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_addr(in_addr), .in_mask(in_mask), .in_depth(in_depth), .in_color(in_color),
    .cmp_mode(cmp_mode), .cache_flush(cache_flush), .stats_clr(stats_clr),
    .sram_rd_en(b_rd_en), .sram_rd_addr(b_rd_addr), .sram_rd_depth(b_rd_depth),
    .sram_wr_en(b_wr_en), .sram_wr_addr(b_wr_addr), .sram_wr_depth(b_wr_depth),
    .sram_wr_color(b_wr_color), .sram_wr_mask(b_wr_mask),
    .pass_count(b_pass_count), .busy(b_busy));

  // SRAM model: masked writes, backdoor preload, read data only valid LAT cycles after rd_en.
  dvec_t      mem [0:255];
  logic       bd_en;
  logic [7:0] bd_addr;
  dvec_t      bd_data;
  logic       rdv_a;
  logic [7:0] rda_a;
  logic [2:0] rdv_b;
  logic [7:0] rda_b [0:2];

  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    for (int i = 0; i < P; i++) begin
      if (a_wr_en && a_wr_mask[i]) mem[a_wr_addr[7:0]][i*DW +: DW] <= a_wr_depth[i*DW +: DW];
      if (b_wr_en && b_wr_mask[i]) mem[b_wr_addr[7:0]][i*DW +: DW] <= b_wr_depth[i*DW +: DW];
    end
    rdv_a    <= a_rd_en;
    rda_a    <= a_rd_addr[7:0];
    rdv_b    <= {rdv_b[1:0], b_rd_en};
    rda_b[0] <= b_rd_addr[7:0];
    rda_b[1] <= rda_b[0];
    rda_b[2] <= rda_b[1];
  end

  assign a_rd_depth = rdv_a    ? mem[rda_a]    : '0;
  assign b_rd_depth = rdv_b[2] ? mem[rda_b[2]] : '0;

  logic     sel_b;
  logic     mon_ready, mon_rd_en, mon_wr_en;
  logic [AW-1:0] mon_rd_addr, mon_wr_addr;
  logic [P-1:0]  mon_wr_mask;
  dvec_t    mon_wr_depth;
  cvec_t    mon_wr_color;
  assign mon_ready    = sel_b ? b_ready    : a_ready;
  assign mon_rd_en    = sel_b ? b_rd_en    : a_rd_en;
  assign mon_rd_addr  = sel_b ? b_rd_addr  : a_rd_addr;
  assign mon_wr_en    = sel_b ? b_wr_en    : a_wr_en;
  assign mon_wr_addr  = sel_b ? b_wr_addr  : a_wr_addr;
  assign mon_wr_mask  = sel_b ? b_wr_mask  : a_wr_mask;
  assign mon_wr_depth = sel_b ? b_wr_depth : a_wr_depth;
  assign mon_wr_color = sel_b ? b_wr_color : a_wr_color;

  int checks = 0;
  int errors = 0;
  int rd_cyc, wr_cyc, ready_cyc;
  logic [AW-1:0] rd_addr_s, wr_addr_s;
  logic [P-1:0]  wr_mask_s;
  dvec_t wr_depth_s, ramp, ramp_merged;
  cvec_t wr_color_s;

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic dvec_t rep_d(input int v);
    dvec_t r;
    for (int i = 0; i < P; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic cvec_t rep_c(input logic [CW-1:0] v);
    cvec_t r;
    for (int i = 0; i < P; i++) r[i*CW +: CW] = v;
    return r;
  endfunction

  task automatic preload(input logic [7:0] addr, input dvec_t d);
    bd_en = 1'b1; bd_addr = addr; bd_data = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  // Issue one request at a negedge and watch 8 cycles; cycle c is the c-th negedge after accept.
  task automatic do_op(input bit use_b, input logic [AW-1:0] addr, input logic [P-1:0] mask,
                       input dvec_t d, input cvec_t c, input logic [1:0] mode,
                       input bit flush, input int clr_until);
    sel_b = use_b;
    #1;
    check("ready_before_req", mon_ready, 1'b1);
    a_valid = !use_b; b_valid = use_b;
    in_addr = addr; in_mask = mask; in_depth = d; in_color = c; cmp_mode = mode;
    cache_flush = flush; stats_clr = (clr_until != 0);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; cache_flush = 1'b0;
    in_depth = '1; in_mask = '0; in_addr = '1;
    rd_cyc = 0; wr_cyc = 0; ready_cyc = 0;
    rd_addr_s = '0; wr_addr_s = '0; wr_mask_s = '0; wr_depth_s = '0; wr_color_s = '0;
    for (int cy = 1; cy <= 8; cy++) begin
      if (cy > 1) @(negedge clk);
      if (cy == clr_until) stats_clr = 1'b0;
      if (mon_rd_en && rd_cyc == 0) begin rd_cyc = cy; rd_addr_s = mon_rd_addr; end
      if (mon_wr_en && wr_cyc == 0) begin
        wr_cyc = cy; wr_addr_s = mon_wr_addr; wr_mask_s = mon_wr_mask;
        wr_depth_s = mon_wr_depth; wr_color_s = mon_wr_color;
      end
      if (mon_ready && ready_cyc == 0) ready_cyc = cy;
    end
  endtask

  initial begin
    srst_n = 1'b0; sel_b = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; in_addr = '0; in_mask = '0; in_depth = '0; in_color = '0;
    cmp_mode = 2'd0; cache_flush = 1'b0; stats_clr = 1'b0; bd_en = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < P; i++) begin
      ramp[i*DW +: DW]        = DW'(10 * i);
      ramp_merged[i*DW +: DW] = (i < 5) ? DW'(10 * i) : DW'(45);
    end
    repeat (2) @(negedge clk);
    check("rst_in_ready", a_ready, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_strobes", {a_rd_en, a_wr_en, a_wr_mask}, '0);
    check("rst_pass_count", a_pass_count, 32'd0);
    srst_n = 1'b1;
    preload(8'h10, rep_d(200));
    preload(8'h20, rep_d(50));
    preload(8'h30, ramp);
    preload(8'h40, rep_d(200));
    preload(8'h50, rep_d(200));

    // Miss, LESS, latency 1
    do_op(0, 16'h0010, 16'hFFFF, rep_d(100), rep_c(24'hABCDEF), 2'd0, 0, 0);
    check("miss_rd_cyc", rd_cyc, 1);
    check("miss_rd_addr", rd_addr_s, 16'h0010);
    check("miss_wr_cyc", wr_cyc, 3);
    check("miss_ready_cyc", ready_cyc, 4);
    check("miss_wr_addr", wr_addr_s, 16'h0010);
    check("miss_wr_mask", wr_mask_s, 16'hFFFF);
    check("miss_wr_depth", wr_depth_s, rep_d(100));
    check("miss_wr_color", wr_color_s, rep_c(24'hABCDEF));
    check("miss_pass_count", a_pass_count, 32'd16);

    // Hit, nothing passes (150 < 100 false)
    do_op(0, 16'h0010, 16'h00FF, rep_d(150), rep_c(24'h111111), 2'd0, 0, 0);
    check("hit_no_rd", rd_cyc, 0);
    check("hit_no_wr", wr_cyc, 0);
    check("hit_ready_cyc", ready_cyc, 3);
    check("hit_pass_count", a_pass_count, 32'd16);
    // Hit again, LEQUAL 100<=100 on pixel 0 proves cache still holds 100
    do_op(0, 16'h0010, 16'h0001, rep_d(100), rep_c(24'h222222), 2'd1, 0, 0);
    check("hit2_no_rd", rd_cyc, 0);
    check("hit2_wr_cyc", wr_cyc, 2);
    check("hit2_wr_mask", wr_mask_s, 16'h0001);
    check("hit2_wr_depth", wr_depth_s, rep_d(100));
    check("hit2_pass_count", a_pass_count, 32'd17);

    // Modes with stored 50 vs new 50
    do_op(0, 16'h0020, 16'hFFFF, rep_d(50), rep_c(24'h333333), 2'd0, 0, 0);
    check("less_rd_cyc", rd_cyc, 1);
    check("less_no_wr", wr_cyc, 0);
    check("less_ready_cyc", ready_cyc, 4);
    do_op(0, 16'h0020, 16'hFFFF, rep_d(50), rep_c(24'h333333), 2'd1, 0, 0);
    check("lequal_wr_cyc", wr_cyc, 2);
    check("lequal_wr_mask", wr_mask_s, 16'hFFFF);
    check("lequal_pass_count", a_pass_count, 32'd33);
    do_op(0, 16'h0020, 16'h8001, rep_d(50), rep_c(24'h333333), 2'd2, 0, 0);
    check("always_wr_mask", wr_mask_s, 16'h8001);
    check("always_pass_count", a_pass_count, 32'd35);
    do_op(0, 16'h0020, 16'hFFFF, rep_d(0), rep_c(24'h333333), 2'd3, 0, 0);
    check("never_no_wr", wr_cyc, 0);
    check("never_pass_count", a_pass_count, 32'd35);

    // Mixed: stored 10*i, new 45, LESS -> pixels 5..15 pass
    do_op(0, 16'h0030, 16'hFFFF, rep_d(45), rep_c(24'h444444), 2'd0, 0, 0);
    check("ramp_wr_mask", wr_mask_s, 16'hFFE0);
    check("ramp_wr_depth", wr_depth_s, ramp_merged);
    check("ramp_pass_count", a_pass_count, 32'd46);

    // Flush on a would-be hit: SRAM now holds 1000, cache holds <=45
    preload(8'h30, rep_d(1000));
    do_op(0, 16'h0030, 16'hFFFF, rep_d(500), rep_c(24'h555555), 2'd0, 1, 0);
    check("flush_rd_cyc", rd_cyc, 1);
    check("flush_wr_mask", wr_mask_s, 16'hFFFF);
    check("flush_wr_depth", wr_depth_s, rep_d(500));
    check("flush_pass_count", a_pass_count, 32'd62);

    // stats_clr alone, then coincident with a write-back increment
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    check("clr_idle", a_pass_count, 32'd0);
    do_op(0, 16'h0030, 16'h000F, rep_d(500), rep_c(24'h666666), 2'd2, 0, 3);
    check("clr_wr_cyc", wr_cyc, 2);
    check("clr_wr_mask", wr_mask_s, 16'h000F);
    check("clr_coincident", a_pass_count, 32'd4);

    // Latency 3 instance
    do_op(1, 16'h0040, 16'hFFFF, rep_d(100), rep_c(24'h777777), 2'd0, 0, 0);
    check("lat3_rd_cyc", rd_cyc, 1);
    check("lat3_wr_cyc", wr_cyc, 5);
    check("lat3_ready_cyc", ready_cyc, 6);
    check("lat3_wr_depth", wr_depth_s, rep_d(100));
    check("lat3_pass_count", b_pass_count, 32'd16);

    // Reset while in WAIT
    sel_b = 1'b0;
    a_valid = 1'b1; in_addr = 16'h0050; in_mask = 16'hFFFF; in_depth = rep_d(100); cmp_mode = 2'd0;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", a_busy, 1'b1);
    srst_n = 1'b0;
    #1;
    check("midrst_in_ready", a_ready, 1'b1);
    check("midrst_busy", a_busy, 1'b0);
    check("midrst_strobes", {a_rd_en, a_wr_en, a_wr_mask}, '0);
    check("midrst_pass_count", a_pass_count, 32'd0);
    check("midrst_pass_count_b", b_pass_count, 32'd0);
    repeat (2) @(negedge clk);
    srst_n = 1'b1;
    do_op(0, 16'h0050, 16'hFFFF, rep_d(100), rep_c(24'h888888), 2'd0, 0, 0);
    check("postrst_rd_cyc", rd_cyc, 1);
    check("postrst_wr_mask", wr_mask_s, 16'hFFFF);
    check("postrst_pass_count", a_pass_count, 32'd16);
    do_op(0, 16'h0030, 16'hFFFF, rep_d(400), rep_c(24'h999999), 2'd0, 0, 0);
    check("postrst_old_tag_miss", rd_cyc, 1);
    check("postrst_old_tag_mask", wr_mask_s, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zbuf_rmw_unit.md
Name: zbuf_rmw_unit

Overview:
- Parametrised depth-test and write-back engine for the rasterizer's pixel-word interface.
- Takes a word of PIX_PER_WORD candidate pixels (depth, color and coverage mask) and reads the stored depths from the depth/color SRAM.
- Applies a selectable depth-compare mode and writes back only the passing pixels through a per-pixel write mask.
- A one-entry last-word cache skips the SRAM read on back-to-back hits to the same address. It sits between Rasterization and the color/depth SRAM.

Parameters:
PIX_PER_WORD, 16, pixels per SRAM word
DEPTH_W, 21, unsigned depth width per pixel
COLOR_W, 24, RGB color width per pixel
ADDR_W, 16, SRAM word address width
SRAM_RD_LAT, 1, SRAM read latency in cycles (>=1)
CNT_W, 32, pass counter width

Ports:
clk  in  1  clock
srst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready at posedge
in_addr  in  ADDR_W  target word address
in_mask  in  PIX_PER_WORD  coverage, 1 = pixel inside triangle
in_depth  in  PIX_PER_WORD*DEPTH_W  candidate depths, pixel i at [i*DEPTH_W +: DEPTH_W]
in_color  in  PIX_PER_WORD*COLOR_W  candidate colors, same packing
cmp_mode  in  2  0 LESS, 1 LEQUAL, 2 ALWAYS, 3 NEVER; sampled at accept
cache_flush  in  1  invalidate last-word cache
stats_clr  in  1  clear pass_count
sram_rd_en  out  1  read strobe
sram_rd_addr  out  ADDR_W  read address
sram_rd_depth  in  PIX_PER_WORD*DEPTH_W  stored depths, valid SRAM_RD_LAT cycles after sram_rd_en
sram_wr_en  out  1  write strobe
sram_wr_addr  out  ADDR_W  write address
sram_wr_depth  out  PIX_PER_WORD*DEPTH_W  merged depths
sram_wr_color  out  PIX_PER_WORD*COLOR_W  candidate colors
sram_wr_mask  out  PIX_PER_WORD  1 = write pixel i
pass_count  out  CNT_W  total pixels passed since reset/clear
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, cache invalid, all outputs 0 except in_ready=1. Requests are ignored while srst_n=0. A request in flight is dropped, no write issued.
- States: IDLE, RD, WAIT, CMP, WR. in_ready = (state==IDLE); busy = !in_ready.
- IDLE: on accept, latch addr/mask/depth/color/cmp_mode.
  - Hit (cache_valid, cache_addr==in_addr, no cache_flush that cycle): go CMP with old depth = cache depth.
  - Otherwise: go RD.
- RD (1 cycle): sram_rd_en=1, sram_rd_addr=latched addr. Next state WAIT, counter=SRAM_RD_LAT.
- WAIT: counter decrements each cycle. In the last WAIT cycle, sram_rd_depth is captured together with the compare result. Then go WR.
- CMP (hit only, 1 cycle): capture compare result vs cache depth, then go WR.
- Compare: pass[i] = mask[i] & f(new_i, old_i), unsigned.
  - LESS: new<old. LEQUAL: new<=old. ALWAYS: 1. NEVER: 0.
  - merged_i = pass[i] ? new_i : old_i.
- WR (1 cycle):
  - sram_wr_en = (pass!=0); addr = latched addr; depth = merged; color = latched color; mask = pass. Strobes are 0 outside RD/WR.
  - Cache updated: valid=1, addr, depth=merged, even when pass==0.
  - pass_count += popcount(pass), wrapping mod 2^CNT_W.
  - Next state IDLE.
- Latency from accept edge T:
  - Miss: rd_en in cycle T+1, wr_en in cycle T+2+SRAM_RD_LAT, in_ready high again at T+3+SRAM_RD_LAT.
  - Hit: wr_en in T+2, in_ready high at T+3.
- cache_flush: clears cache_valid at the next edge in any state. It overrides a same-cycle WR cache update (valid=0) and forces a miss on a same-cycle accept.
- stats_clr: pass_count=0 at next edge. If coincident with a WR increment, the result is popcount(pass), so the clear applies first.
- Input data need only be stable at the accept edge. sram_rd_depth is sampled only at the capture edge.

Test Plan:
- Miss, LESS, SRAM_RD_LAT=1: addr=0x0010, mask=0xFFFF, all new=100, stored=200. Expect rd_en cycle T+1; wr_en cycle T+3, wr_mask=0xFFFF, depths=100; pass_count=16.
- Hit path: repeat addr=0x0010, new=150 for all pixels, mask=0x00FF. Expect no rd_en; wr_en at T+2, wr_mask=0x0000 → wr_en=0; pass_count stays 16; cache depth still 100.
- Mode check, per pixel stored=50 vs new=50: LESS writes none; LEQUAL writes mask=0xFFFF; ALWAYS with mask=0x8001 writes 0x8001; NEVER writes none, pass_count unchanged.
- Flush: cache_flush=1 on the accept cycle of a would-be hit. Expect rd_en issued; stored value from the SRAM model is used.
- SRAM_RD_LAT=3: miss at T. Expect wr_en at T+5, in_ready=0 for cycles T+1..T+5.
- Reset mid-op: drop srst_n during WAIT. Expect immediate in_ready=1, busy=0, strobes=0, pass_count=0, and a following same-address request treated as a miss.
